// File: rtl/array_packed_3d_pkg.sv
// rtl/array_packed_3d_pkg.sv - shared constants, types and helpers for the packed 3D array reader
package array_packed_3d_pkg;

    localparam int DEF_DIM_I = 4;
    localparam int DEF_DIM_J = 3;
    localparam int DEF_DIM_K = 2;
    localparam int DEF_DW    = 8;
    localparam int SUM_W     = 16;

    typedef logic [DEF_DW-1:0] elem_t;
    typedef logic [DEF_DIM_I-1:0][DEF_DIM_J-1:0][DEF_DIM_K-1:0][DEF_DW-1:0] array_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width for a dimension; a dimension of 1 still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_packed_3d_idx_cnt.sv
// rtl/array_packed_3d_idx_cnt.sv - nested i/j/k wrap counters with last-element flag
module array_packed_3d_idx_cnt
    import array_packed_3d_pkg::*;
#(
    parameter int DIM_I = DEF_DIM_I,
    parameter int DIM_J = DEF_DIM_J,
    parameter int DIM_K = DEF_DIM_K,
    parameter int IW    = idx_w(DIM_I),
    parameter int JW    = idx_w(DIM_J),
    parameter int KW    = idx_w(DIM_K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [IW-1:0] out_i,
    output logic [JW-1:0] out_j,
    output logic [KW-1:0] out_k,
    output logic          last
);

    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;

    logic k_wrap, j_wrap, i_wrap;

    always_comb begin
        k_wrap = (k_q == KW'(DIM_K - 1));
        j_wrap = (j_q == JW'(DIM_J - 1));
        i_wrap = (i_q == IW'(DIM_I - 1));
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        if (clear) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (advance) begin
            // k is innermost: j only moves when k wraps, i only when both wrap
            if (!k_wrap) begin
                k_d = k_q + KW'(1);
            end else begin
                k_d = '0;
                if (!j_wrap) begin
                    j_d = j_q + JW'(1);
                end else begin
                    j_d = '0;
                    i_d = i_wrap ? '0 : i_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign out_i = i_q;
    assign out_j = j_q;
    assign out_k = k_q;
    assign last  = i_wrap && j_wrap && k_wrap;

endmodule

// File: rtl/array_packed_3d_reader.sv
// rtl/array_packed_3d_reader.sv - snapshots a packed 3D array and streams its elements i/j/k-ordered
module array_packed_3d_reader
    import array_packed_3d_pkg::*;
#(
    parameter int DIM_I = DEF_DIM_I,
    parameter int DIM_J = DEF_DIM_J,
    parameter int DIM_K = DEF_DIM_K,
    parameter int DW    = DEF_DW,
    parameter int IW    = idx_w(DIM_I),
    parameter int JW    = idx_w(DIM_J),
    parameter int KW    = idx_w(DIM_K)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [DIM_I*DIM_J*DIM_K*DW-1:0] array_in,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DW-1:0]                   out_data,
    output logic [IW-1:0]                   out_i,
    output logic [JW-1:0]                   out_j,
    output logic [KW-1:0]                   out_k,
    output logic                            out_last,
    output logic                            done,
    output logic [SUM_W-1:0]                sum
);

    typedef logic [DIM_I-1:0][DIM_J-1:0][DIM_K-1:0][DW-1:0] snap_t;

    state_t           state_q, state_d;
    snap_t            snap_q, snap_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic    capture;
    logic    handshake;
    logic    last;
    logic [DW-1:0] elem;

    array_packed_3d_idx_cnt #(
        .DIM_I (DIM_I),
        .DIM_J (DIM_J),
        .DIM_K (DIM_K),
        .IW    (IW),
        .JW    (JW),
        .KW    (KW)
    ) u_idx_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (capture),
        .advance (handshake),
        .out_i   (out_i),
        .out_j   (out_j),
        .out_k   (out_k),
        .last    (last)
    );

    assign elem      = snap_q[out_i][out_j][out_k];
    assign capture   = (state_q == ST_IDLE) && start;
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    snap_d      = array_in;
                    acc_d       = '0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    acc_d = acc_q + SUM_W'(elem);
                    if (last) begin
                        // Publish the total on the same edge so sum is already final in DONE
                        state_d     = ST_DONE;
                        sum_d       = acc_d;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? elem : '0;
    assign out_last  = out_valid_q && last;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;

endmodule
